// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard scheduler: FSM states,
// forward-select encodings and the scoreboard entry layout.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL_LD = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Wide enough for any supported register-specifier width.
  localparam int SB_DEST_W = 8;

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 mem_read;
    logic [SB_DEST_W-1:0] dest;
  } sb_entry_t;

  function automatic logic sb_writes(
    input sb_entry_t            e,
    input logic [SB_DEST_W-1:0] r
  );
    return e.valid && e.reg_write && (e.dest != '0) && (e.dest == r);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry EX/MEM/WB shift scoreboard with source-match outputs
// used for load-use detection and forwarding.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_ex,
  input  sb_entry_t            ex_in,
  input  logic [NREG_BITS-1:0] rs,
  input  logic [NREG_BITS-1:0] rt,
  output logic                 ex_hit_rs,
  output logic                 ex_hit_rt,
  output logic                 mem_hit_rs,
  output logic                 mem_hit_rt,
  output logic                 ld_hit_rs,
  output logic                 ld_hit_rt,
  output sb_entry_t            wb_entry
);

  sb_entry_t ex_q, ex_d;
  sb_entry_t mem_q, mem_d;
  sb_entry_t wb_q, wb_d;
  logic [SB_DEST_W-1:0] rs_w, rt_w;
  logic ld_ex;

  always_comb begin
    ex_d  = load_ex ? ex_in : '0;
    mem_d = ex_q;
    wb_d  = mem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign rs_w = SB_DEST_W'(rs);
  assign rt_w = SB_DEST_W'(rt);

  // A load in EX cannot forward yet; it can only cause a stall.
  assign ld_ex = ex_q.valid && ex_q.mem_read && (ex_q.dest != '0);

  assign ex_hit_rs  = sb_writes(ex_q, rs_w) && !ex_q.mem_read;
  assign ex_hit_rt  = sb_writes(ex_q, rt_w) && !ex_q.mem_read;
  assign mem_hit_rs = sb_writes(mem_q, rs_w);
  assign mem_hit_rt = sb_writes(mem_q, rt_w);
  assign ld_hit_rs  = ld_ex && (ex_q.dest == rs_w);
  assign ld_hit_rt  = ld_ex && (ex_q.dest == rt_w);
  assign wb_entry   = wb_q;

endmodule

// File: rtl/id_hazard_scheduler.sv
// ID-stage hazard scheduler: load-use stall, flush and forward selects.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module id_hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int NREG_BITS = 5,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [NREG_BITS-1:0] id_rs,
  input  logic [NREG_BITS-1:0] id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic [NREG_BITS-1:0] id_dest,
  input  logic                 id_jump,
  input  logic                 ex_branch_taken,
  output logic                 id_ready,
  output logic                 issue,
  output logic                 flush_if,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_BITS-1:0]  stall_cnt,
  output logic [CNT_BITS-1:0]  flush_cnt
`endif
);

  state_e     state_q, state_d;
  logic       issue_q, issue_d;
  logic       flush_q, flush_d;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;
  logic       ex_hit_rs, ex_hit_rt;
  logic       mem_hit_rs, mem_hit_rt;
  logic       ld_hit_rs, ld_hit_rt;
  logic       load_use, stall;
  sb_entry_t  ex_in;
  sb_entry_t  wb_entry;

  hazard_scoreboard #(.NREG_BITS(NREG_BITS)) u_sb (
    .clk        (clk),
    .rst        (reset),
    .load_ex    (issue_d),
    .ex_in      (ex_in),
    .rs         (id_rs),
    .rt         (id_rt),
    .ex_hit_rs  (ex_hit_rs),
    .ex_hit_rt  (ex_hit_rt),
    .mem_hit_rs (mem_hit_rs),
    .mem_hit_rt (mem_hit_rt),
    .ld_hit_rs  (ld_hit_rs),
    .ld_hit_rt  (ld_hit_rt),
    .wb_entry   (wb_entry)
  );

  always_comb begin
    ex_in           = '0;
    ex_in.valid     = 1'b1;
    ex_in.reg_write = id_reg_write;
    ex_in.mem_read  = id_mem_read;
    ex_in.dest      = SB_DEST_W'(id_dest);
  end

  // A taken branch overrides a coincident load-use stall.
  assign load_use = id_valid && (state_q == RUN) &&
                    ((id_uses_rs && ld_hit_rs) ||
                     (id_uses_rt && ld_hit_rt));
  assign stall    = load_use && !ex_branch_taken;
  assign id_ready = !stall;

  always_comb begin
    issue_d = id_valid && !stall && !ex_branch_taken &&
              (state_q != FLUSH);
    flush_d = ex_branch_taken || (issue_d && id_jump);
    state_d = RUN;
    if (flush_d)    state_d = FLUSH;
    else if (stall) state_d = STALL_LD;
    fwd_a_d = FWD_REG;
    fwd_b_d = FWD_REG;
    if (issue_d && id_uses_rs) begin
      if (ex_hit_rs)       fwd_a_d = FWD_EXMEM;
      else if (mem_hit_rs) fwd_a_d = FWD_MEMWB;
    end
    if (issue_d && id_uses_rt) begin
      if (ex_hit_rt)       fwd_b_d = FWD_EXMEM;
      else if (mem_hit_rt) fwd_b_d = FWD_MEMWB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      issue_q <= 1'b0;
      flush_q <= 1'b0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      flush_q <= flush_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign issue    = issue_q;
  assign flush_if = flush_q;
  assign fwd_a    = fwd_a_q;
  assign fwd_b    = fwd_b_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_BITS-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == STALL_LD) && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_q && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// Directed bench for id_hazard_scheduler; expected registered outputs
// are queued at drive time and compared one cycle later.
module tb_id_hazard_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt;
  logic       id_reg_write, id_mem_read;
  logic       id_jump, ex_branch_taken;
  logic       id_ready, issue, flush_if;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_STATS_EN
  logic [3:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       iss;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       fl;
  } exp_t;

  exp_t exp_q[$];

  id_hazard_scheduler #(.NREG_BITS(5), .CNT_BITS(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_dest         (id_dest),
    .id_jump         (id_jump),
    .ex_branch_taken (ex_branch_taken),
    .id_ready        (id_ready),
    .issue           (issue),
    .flush_if        (flush_if),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, ".issue"}, 32'(issue), 32'(e.iss));
      check({tag, ".fwd_a"}, 32'(fwd_a), 32'(e.fa));
      check({tag, ".fwd_b"}, 32'(fwd_b), 32'(e.fb));
      check({tag, ".flush"}, 32'(flush_if), 32'(e.fl));
    end
  endtask

  // One ID cycle: v rs rt urs urt rw mr dest jmp br | ready iss fa fb fl
  task automatic step(input string tag,
                      input logic v, input logic [4:0] rs, rt,
                      input logic urs, urt, rw, mr,
                      input logic [4:0] dst,
                      input logic jmp, br,
                      input logic e_rdy, e_iss,
                      input logic [1:0] e_fa, e_fb,
                      input logic e_fl);
    exp_t e;
    @(negedge clk);
    pop_check(tag);
    id_valid = v; id_rs = rs; id_rt = rt;
    id_uses_rs = urs; id_uses_rt = urt;
    id_reg_write = rw; id_mem_read = mr; id_dest = dst;
    id_jump = jmp; ex_branch_taken = br;
    #1;
    check({tag, ".ready"}, 32'(id_ready), 32'(e_rdy));
    e.iss = e_iss; e.fa = e_fa; e.fb = e_fb; e.fl = e_fl;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".issue"}, 32'(issue), 0);
    check({tag, ".flush"}, 32'(flush_if), 0);
    check({tag, ".fwd_a"}, 32'(fwd_a), 0);
    check({tag, ".fwd_b"}, 32'(fwd_b), 0);
    check({tag, ".ready"}, 32'(id_ready), 1);
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_dest = 0;
    id_uses_rs = 0; id_uses_rt = 0;
    id_reg_write = 0; id_mem_read = 0;
    id_jump = 0; ex_branch_taken = 0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
`ifdef HAZARD_STATS_EN
    check("rst.stall_cnt", 32'(stall_cnt), 0);
`endif
    reset = 1'b0;

    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    // load-use: lw $8 then add uses $8
    step("lw8",  1, 1, 0, 1, 0, 1, 1, 8, 0, 0, 1, 1, 2'b00, 2'b00, 0);
    step("lu",   1, 8, 2, 1, 1, 1, 0, 10, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    step("luiss",1, 8, 2, 1, 1, 1, 0, 10, 0, 0, 1, 1, 2'b10, 2'b00, 0);
    // ALU forward from EX/MEM then MEM/WB
    step("add9", 1, 3, 4, 1, 1, 1, 0, 9, 0, 0, 1, 1, 2'b00, 2'b00, 0);
    step("sub",  1, 5, 9, 1, 1, 1, 0, 11, 0, 0, 1, 1, 2'b00, 2'b01, 0);
    step("or",   1, 6, 9, 1, 1, 1, 0, 12, 0, 0, 1, 1, 2'b00, 2'b10, 0);
    // $0 never stalls or forwards
    step("lw0",  1, 7, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0);
    step("rd0",  1, 0, 0, 1, 1, 1, 0, 14, 0, 0, 1, 1, 2'b00, 2'b00, 0);
    // EX match beats MEM match
    step("a13a", 1, 0, 0, 0, 0, 1, 0, 13, 0, 0, 1, 1, 2'b00, 2'b00, 0);
    step("a13b", 1, 0, 0, 0, 0, 1, 0, 13, 0, 0, 1, 1, 2'b00, 2'b00, 0);
    step("prio", 1, 13, 13, 1, 1, 1, 0, 15, 0, 0, 1, 1, 2'b01, 2'b01, 0);
    // issued jump flushes, wrong-path slot is killed
    step("jal",  1, 0, 0, 0, 0, 1, 0, 31, 1, 0, 1, 1, 2'b00, 2'b00, 1);
    step("jflsh",1, 31, 0, 1, 0, 1, 0, 16, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    step("pjal", 1, 31, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10, 2'b00, 0);
    // branch coinciding with load-use: flush wins
    step("lw8b", 1, 0, 0, 0, 0, 1, 1, 8, 0, 0, 1, 1, 2'b00, 2'b00, 0);
    step("brlu", 1, 8, 0, 1, 0, 1, 0, 10, 0, 1, 1, 0, 2'b00, 2'b00, 1);
    step("bflsh",1, 8, 0, 1, 0, 1, 0, 10, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    step("pbr",  1, 8, 0, 1, 0, 1, 0, 10, 0, 0, 1, 1, 2'b00, 2'b00, 0);
`ifdef HAZARD_STATS_EN
    check("br.stall_cnt", 32'(stall_cnt), 1);
    check("br.flush_cnt", 32'(flush_cnt), 2);
`endif
    // reset while in STALL_LD
    step("lw8c", 1, 0, 0, 0, 0, 1, 1, 8, 0, 0, 1, 1, 2'b00, 2'b00, 0);
    step("luc",  1, 8, 0, 1, 0, 1, 0, 10, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    @(posedge clk);
    #1;
    pop_check("luc");
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
`ifdef HAZARD_STATS_EN
    check("midrst.stall_cnt", 32'(stall_cnt), 0);
`endif
    @(negedge clk);
    id_valid = 0;
    reset = 1'b0;
    step("indep",1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0);

    for (int i = 0; i < 20; i++) begin
      step("slw", 1, 0, 0, 0, 0, 1, 1, 8, 0, 0, 1, 1, 2'b00, 2'b00, 0);
      step("slu", 1, 8, 0, 1, 0, 1, 0, 10, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      step("siss",1, 8, 0, 1, 0, 1, 0, 10, 0, 0, 1, 1, 2'b10, 2'b00, 0);
    end
    step("end",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    @(negedge clk);
    pop_check("end");
    check("queue_empty", 32'(exp_q.size()), 0);
`ifdef HAZARD_STATS_EN
    check("sat.stall_cnt", 32'(stall_cnt), 15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_hazard_scheduler.md
ID_HAZARD_SCHEDULER -- requirements
Module: id_hazard_scheduler

Interface
REQ-001 Parameter: NREG_BITS, default 5, register-specifier width.
REQ-002 Parameter: CNT_BITS, default 16, width of statistics counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 id_valid  input  1  decoded instruction present in ID.
REQ-006 id_rs, id_rt  input  NREG_BITS each  source specifiers of the ID instruction.
REQ-007 id_uses_rs, id_uses_rt  input  1 each  instruction reads rs / rt.
REQ-008 id_reg_write, id_mem_read  input  1 each  decoded RegWrite / MemRead.
REQ-009 id_dest  input  NREG_BITS  final write register after RegDst/link selection.
REQ-010 id_jump  input  1  decoded jump (J/JAL/JR) in ID.
REQ-011 ex_branch_taken  input  1  branch in EX resolved taken this cycle.
REQ-012 id_ready  output  1  ID may accept/hold; 0 = stall IF and ID.
REQ-013 issue  output  1  registered; instruction entered EX this cycle.
REQ-014 flush_if  output  1  registered one-cycle kill of IF/ID register.
REQ-015 fwd_a, fwd_b  output  2 each  registered EX operand selects: 00 regfile, 01 EX/MEM, 10 MEM/WB.
REQ-016 stall_cnt, flush_cnt  output  CNT_BITS each  statistics (only with macro, REQ-033).

Function
REQ-017 Scoreboard SHALL hold 3 entries (EX, MEM, WB), each {valid, reg_write, mem_read, dest}, shifting EX->MEM->WB every cycle.
REQ-018 On issue the ID instruction's fields SHALL load the EX entry; otherwise EX entry SHALL load a bubble (valid=0).
REQ-019 Load-use hazard: EX entry valid, mem_read, dest!=0, dest equals a used ID source -> id_ready=0 for exactly one cycle, bubble inserted.
REQ-020 Issue SHALL occur when id_valid && id_ready && no flush condition.
REQ-021 Forward select for each source, computed at issue: EX entry match (reg_write, dest!=0, not mem_read) -> 01; else MEM entry match (reg_write, dest!=0) -> 10; else 00; EX match has priority.
REQ-022 Register 0 SHALL never cause a stall or a non-zero forward select.
REQ-023 FSM states RUN, STALL_LD, FLUSH: RUN->STALL_LD on load-use; STALL_LD->RUN next cycle; any->FLUSH on ex_branch_taken or issued id_jump; FLUSH->RUN next cycle.
REQ-024 ex_branch_taken SHALL suppress issue in that cycle and assert flush_if next cycle; the ID instruction becomes a bubble.
REQ-025 Issued id_jump SHALL assert flush_if next cycle; jump itself issues.
REQ-026 In FLUSH, issue SHALL be 0 and fwd selects 00.
REQ-027 Simultaneous ex_branch_taken and load-use: flush wins; stall discarded, no STALL_LD entry.
REQ-028 id_valid=0: no issue, bubble inserted, fwd selects 00, id_ready=1 unless load-use.
REQ-029 Latency: issue, fwd_a/b and flush_if valid one cycle after the ID-cycle decision.

Reset
REQ-030 Reset SHALL clear scoreboard valid bits, state to RUN, issue=0, flush_if=0, fwd_a=fwd_b=00, counters 0; id_ready=1 after reset.
REQ-031 Reset asserted mid-stall or mid-flush SHALL abort it; first cycle after release behaves as empty pipeline.

Configuration
REQ-032 Macro HAZARD_STATS_EN SHALL control statistics.
REQ-033 With HAZARD_STATS_EN: stall_cnt increments per STALL_LD cycle, flush_cnt per flush_if pulse, both saturate at all-ones; without it ports are absent and no counter logic exists.

Structure
REQ-034 Package hazard_pkg SHALL hold FSM state enum, fwd encodings (FWD_REG, FWD_EXMEM, FWD_MEMWB) and scoreboard entry typedef.
REQ-035 Sub-module hazard_scoreboard SHALL implement the 3-entry shift pipeline and match outputs; FSM, forwarding and counters stay in top.

Verification
REQ-036 lw $8 issued, next add uses rs=$8 -> id_ready=0 one cycle, bubble, add issues with fwd_a=10.
REQ-037 add $9 issued, next sub uses rt=$9 -> no stall, fwd_b=01; one instruction later -> fwd_b=10.
REQ-038 Instruction writing $0 followed by reader of $0 -> no stall, fwd selects 00.
REQ-039 ex_branch_taken=1 coinciding with load-use -> issue=0, flush_if=1 next cycle, id_ready not held low, stall_cnt unchanged.
REQ-040 Reset asserted during STALL_LD -> outputs to REQ-030 values immediately; after release, independent add issues with fwd 00.
REQ-041 With HAZARD_STATS_EN, CNT_BITS=4, 20 load-use stalls -> stall_cnt=15 (saturated).
